// File: rtl/adc_sample_scheduler_pkg.sv
// Shared constants for the ADC -> PID sample path: default widths and scheduler FSM states.
package adc_sample_scheduler_pkg;
    localparam int DEF_W_IN   = 18;
    localparam int DEF_N_CHAN = 8;
    localparam int DEF_W_CHAN = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } sched_state_t;
endpackage

// File: rtl/adc_sample_scheduler_rr_arbiter.sv
// Round-robin search over pending channels, starting one past the last grant and wrapping.
module rr_arbiter #(
    parameter int N_CHAN = 8,
    parameter int W_CHAN = 3
) (
    input  logic [N_CHAN-1:0] pend_in,
    input  logic [W_CHAN-1:0] ptr_in,
    output logic [N_CHAN-1:0] gnt_out,
    output logic [W_CHAN-1:0] idx_out,
    output logic              any_out
);
    always_comb begin
        gnt_out = '0;
        idx_out = '0;
        any_out = 1'b0;
        for (int k = 1; k <= N_CHAN; k++) begin
            int j;
            j = (int'(ptr_in) + k) % N_CHAN;
            if (!any_out && pend_in[j]) begin
                any_out    = 1'b1;
                idx_out    = W_CHAN'(j);
                gnt_out[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/adc_sample_scheduler.sv
// Captures paired ADC port samples into per-channel holding registers and feeds them
// one at a time to the PID core over valid/ready, flagging channels that get overwritten.
module adc_sample_scheduler
    import adc_sample_scheduler_pkg::*;
#(
    parameter int W_IN   = DEF_W_IN,
    parameter int N_CHAN = DEF_N_CHAN,
    parameter int W_CHAN = DEF_W_CHAN
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [N_CHAN-1:0]        chan_en_in,
    input  logic                     clr_ovr_in,
    input  logic [N_CHAN-1:0]        data_valid_in,
    input  logic signed [W_IN-1:0]   data_a_in,
    input  logic signed [W_IN-1:0]   data_b_in,
    input  logic                     rdy_in,
    output logic                     data_valid_out,
    output logic signed [W_IN-1:0]   data_out,
    output logic [W_CHAN-1:0]        chan_out,
    output logic [N_CHAN-1:0]        pending_out,
    output logic [N_CHAN-1:0]        ovr_out
);
    localparam int HALF = N_CHAN / 2;

    sched_state_t             r_state;
    logic [W_CHAN-1:0]        r_ptr;
    logic [N_CHAN-1:0]        r_pend;
    logic [N_CHAN-1:0]        r_ovr;
    logic signed [W_IN-1:0]   r_buf [N_CHAN];

    logic [N_CHAN-1:0]        w_cap;
    logic [N_CHAN-1:0]        w_arb_pend;
    logic [N_CHAN-1:0]        w_gnt_raw;
    logic [N_CHAN-1:0]        w_gnt;
    logic [W_CHAN-1:0]        w_idx;
    logic                     w_any;
    logic                     w_load;

    assign w_cap      = data_valid_in & chan_en_in;
    // A channel being disabled on this edge must not win the grant.
    assign w_arb_pend = r_pend & chan_en_in;

    rr_arbiter #(.N_CHAN(N_CHAN), .W_CHAN(W_CHAN)) u_arb (
        .pend_in (w_arb_pend),
        .ptr_in  (r_ptr),
        .gnt_out (w_gnt_raw),
        .idx_out (w_idx),
        .any_out (w_any)
    );

    assign w_load = w_any && (r_state == ST_IDLE || rdy_in);
    assign w_gnt  = w_load ? w_gnt_raw : '0;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_pend <= '0;
            r_ovr  <= '0;
            for (int i = 0; i < N_CHAN; i++) r_buf[i] <= '0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (w_cap[i]) r_buf[i] <= (i < HALF) ? data_a_in : data_b_in;

                // A capture landing on the channel being granted refills it, not an overrun.
                if (!chan_en_in[i])  r_pend[i] <= 1'b0;
                else if (w_cap[i])   r_pend[i] <= 1'b1;
                else if (w_gnt[i])   r_pend[i] <= 1'b0;

                if (w_cap[i] && r_pend[i] && !w_gnt[i]) r_ovr[i] <= 1'b1;
                else if (clr_ovr_in)                     r_ovr[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state        <= ST_IDLE;
            r_ptr          <= W_CHAN'(N_CHAN - 1);
            data_valid_out <= 1'b0;
            data_out       <= '0;
            chan_out       <= '0;
        end else begin
            if (w_load) begin
                data_out       <= r_buf[w_idx];
                chan_out       <= w_idx;
                data_valid_out <= 1'b1;
                r_ptr          <= w_idx;
                r_state        <= ST_PRESENT;
            end else if (r_state == ST_PRESENT && rdy_in) begin
                data_valid_out <= 1'b0;
                r_state        <= ST_IDLE;
            end
        end
    end

    assign pending_out = r_pend;
    assign ovr_out     = r_ovr;
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler: capture, back-to-back grant order, overrun, enable, async reset.
module tb_adc_sample_scheduler;
    logic                clk_in = 1'b0;
    logic                reset_in;
    logic [7:0]          chan_en_in;
    logic                clr_ovr_in;
    logic [7:0]          data_valid_in;
    logic signed [17:0]  data_a_in;
    logic signed [17:0]  data_b_in;
    logic                rdy_in;
    logic                data_valid_out;
    logic signed [17:0]  data_out;
    logic [2:0]          chan_out;
    logic [7:0]          pending_out;
    logic [7:0]          ovr_out;

    int total = 0;
    int bad   = 0;

    adc_sample_scheduler dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .chan_en_in     (chan_en_in),
        .clr_ovr_in     (clr_ovr_in),
        .data_valid_in  (data_valid_in),
        .data_a_in      (data_a_in),
        .data_b_in      (data_b_in),
        .rdy_in         (rdy_in),
        .data_valid_out (data_valid_out),
        .data_out       (data_out),
        .chan_out       (chan_out),
        .pending_out    (pending_out),
        .ovr_out        (ovr_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int order [8] = '{3, 4, 5, 6, 7, 0, 1, 2};

        reset_in = 1'b1; chan_en_in = 8'hFF; clr_ovr_in = 1'b0; data_valid_in = 8'h00;
        data_a_in = '0; data_b_in = '0; rdy_in = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(data_valid_out), 0);
        chk("rst_data",  32'(data_out), 0);
        chk("rst_pend",  32'(pending_out), 0);
        chk("rst_ovr",   32'(ovr_out), 0);
        reset_in = 1'b0;
        tick();

        // Paired capture on ch0/ch4, drained back-to-back
        data_valid_in = 8'h11; data_a_in = 18'sd1000; data_b_in = -18'sd5;
        tick();
        data_valid_in = 8'h00;
        chk("cap_pend",   32'(pending_out), 32'h11);
        chk("cap_valid0", 32'(data_valid_out), 0);
        tick();
        chk("p0_valid", 32'(data_valid_out), 1);
        chk("p0_chan",  32'(chan_out), 0);
        chk("p0_data",  32'(data_out), 32'(1000));
        chk("p0_pend",  32'(pending_out), 32'h10);
        tick();
        chk("p4_valid", 32'(data_valid_out), 1);
        chk("p4_chan",  32'(chan_out), 4);
        chk("p4_data",  32'(data_out), 32'(-5));
        tick();
        chk("drain_valid", 32'(data_valid_out), 0);

        // Stall with rdy low
        rdy_in = 1'b0; data_valid_in = 8'h01; data_a_in = 18'sd123;
        tick();
        data_valid_in = 8'h00;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", 32'(data_valid_out), 1);
            chk("stall_chan",  32'(chan_out), 0);
            chk("stall_data",  32'(data_out), 32'(123));
            tick();
        end
        rdy_in = 1'b1;
        tick();
        chk("stall_xfer", 32'(data_valid_out), 0);
        tick();
        chk("stall_once", 32'(data_valid_out), 0);

        // Set ptr=2, then all channels pending
        data_valid_in = 8'h04; data_a_in = 18'sd222;
        tick();
        data_valid_in = 8'h00;
        tick();
        chk("ptr2_chan", 32'(chan_out), 2);
        tick();
        data_valid_in = 8'hFF; data_a_in = 18'sd11; data_b_in = -18'sd22;
        tick();
        data_valid_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_valid", 32'(data_valid_out), 1);
            chk("rr_chan",  32'(chan_out), 32'(order[k]));
        end
        tick();
        chk("rr_done", 32'(data_valid_out), 0);

        // Overrun on ch1 while ch0 stalled
        rdy_in = 1'b0; data_valid_in = 8'h03; data_a_in = 18'sd50;
        tick();
        data_valid_in = 8'h00;
        tick();
        chk("ov_chan0", 32'(chan_out), 0);
        data_valid_in = 8'h02; data_a_in = 18'sd7;
        tick();
        data_valid_in = 8'h00;
        chk("ov_set",  32'(ovr_out), 32'h02);
        chk("ov_pend", 32'(pending_out), 32'h02);
        rdy_in = 1'b1;
        tick();
        chk("ov_chan1", 32'(chan_out), 1);
        chk("ov_data7", 32'(data_out), 32'(7));
        tick();
        chk("ov_idle", 32'(data_valid_out), 0);
        clr_ovr_in = 1'b1;
        tick();
        clr_ovr_in = 1'b0;
        chk("ov_clr", 32'(ovr_out), 0);
        rdy_in = 1'b0; data_valid_in = 8'h0A; data_a_in = 18'sd9;
        tick();
        data_valid_in = 8'h00;
        tick();
        chk("ov2_chan3", 32'(chan_out), 3);
        data_valid_in = 8'h02; clr_ovr_in = 1'b1;
        tick();
        data_valid_in = 8'h00; clr_ovr_in = 1'b0;
        chk("ov_setwins", 32'(ovr_out), 32'h02);
        rdy_in = 1'b1;
        tick(); tick();
        chk("ov2_idle", 32'(data_valid_out), 0);

        // Enable masking
        chan_en_in = 8'hFE; data_valid_in = 8'h01; data_a_in = 18'sd1;
        tick();
        data_valid_in = 8'h00;
        chk("dis_pend", 32'(pending_out), 0);
        tick();
        chk("dis_valid", 32'(data_valid_out), 0);
        chan_en_in = 8'hFF; rdy_in = 1'b0; data_valid_in = 8'h04; data_a_in = 18'sd44;
        tick();
        data_valid_in = 8'h00;
        tick();
        chan_en_in = 8'hFB;
        tick();
        chk("dis2_valid", 32'(data_valid_out), 1);
        chk("dis2_chan",  32'(chan_out), 2);
        chk("dis2_data",  32'(data_out), 32'(44));
        rdy_in = 1'b1;
        tick();
        chk("dis2_xfer", 32'(data_valid_out), 0);
        chan_en_in = 8'hFF;

        // Async reset mid-present
        rdy_in = 1'b0; data_valid_in = 8'h20; data_b_in = 18'sd77;
        tick();
        data_valid_in = 8'h00;
        tick();
        chk("ar_pre_valid", 32'(data_valid_out), 1);
        #2 reset_in = 1'b1;
        #1;
        chk("ar_valid", 32'(data_valid_out), 0);
        chk("ar_data",  32'(data_out), 0);
        chk("ar_chan",  32'(chan_out), 0);
        chk("ar_ovr",   32'(ovr_out), 0);
        #1 reset_in = 1'b0;
        data_valid_in = 8'h09; data_a_in = 18'sd5;
        tick();
        data_valid_in = 8'h00;
        tick();
        chk("ar_first_valid", 32'(data_valid_out), 1);
        chk("ar_first_chan",  32'(chan_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
